// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage and its neighbours:
// opcode constants, the fetch FSM state type and the instruction width.
package instr_fetch_pkg;

  localparam int INSTR_W = 32;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ITYPE = 6'b000001;
  localparam logic [5:0] OP_LW    = 6'b100010;
  localparam logic [5:0] OP_LWI   = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000110;
  localparam logic [5:0] OP_J     = 6'b010000;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_next_pc_calc.sv
// next_pc_calc: combinational redirect decision and target address for the
// instruction held in IF/ID. Jump wins over branch when both are asserted.
module next_pc_calc
  import instr_fetch_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic               en,
  input  logic [INSTR_W-1:0] instr,
  input  logic [ADDR_W-1:0]  pc_plus4,
  input  logic               jump,
  input  logic               branch,
  input  logic               zero,
  output logic               taken,
  output logic [ADDR_W-1:0]  target
);

  // Bits of pc_plus4 kept by a jump (everything above the 28-bit region).
  localparam logic [ADDR_W-1:0] HI_MASK = ~ADDR_W'(28'hFFF_FFFF);

  logic                cond;
  logic [ADDR_W-1:0]   jump_tgt;
  logic [ADDR_W-1:0]   br_off;
  logic [ADDR_W-1:0]   br_tgt;

  // Branch condition (BEQ on zero, others on not-zero) and both target forms.
  always_comb begin
    cond     = (instr[31:26] == OP_BEQ) ? zero : ~zero;
    taken    = en & (jump | (branch & cond));
    jump_tgt = (pc_plus4 & HI_MASK) | ADDR_W'({instr[25:0], 2'b00});
    br_off   = {{(ADDR_W-18){instr[15]}}, instr[15:0], 2'b00};
    br_tgt   = pc_plus4 + br_off;
    target   = jump ? jump_tgt : br_tgt;
  end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: owns the PC, fetches instructions over a req/ack handshake and
// presents them in the IF/ID register. Optional performance counters are
// enabled with the IF_PERF_CNT_EN macro.
//
// Handshake: imem_req is raised in S_REQ/S_DROP and held with a stable
// imem_addr until the cycle imem_ack is high; that cycle carries imem_rdata
// and completes the request. imem_req is a function of state only.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               id_valid,
  output logic [INSTR_W-1:0] id_instr,
  output logic [5:0]         id_opcode,
  output logic [ADDR_W-1:0]  id_pc_plus4,
  input  logic               id_stall,
  input  logic               ctl_jump,
  input  logic               ctl_branch,
  input  logic               alu_zero,
`ifdef IF_PERF_CNT_EN
  output logic [31:0]        perf_fetch,
  output logic [31:0]        perf_flush,
  output logic [31:0]        perf_stall,
`endif
  output fetch_state_t       dbg_state
);

  fetch_state_t       state, state_nxt;
  logic [ADDR_W-1:0]  pc, redir_pc, pc_plus4, target;
  logic [INSTR_W-1:0] skid;
  logic               taken, consume;
  logic               id_load_mem, id_load_skid, skid_wr, pc_inc;
  logic               pc_to_target, save_target, pc_from_redir;

  assign pc_plus4  = pc + ADDR_W'(4);
  assign consume   = id_valid & ~id_stall;
  assign imem_req  = (state == S_REQ) || (state == S_DROP);
  assign imem_addr = pc;
  assign id_opcode = id_instr[31:26];
  assign dbg_state = state;

  next_pc_calc #(.ADDR_W(ADDR_W)) u_next_pc (
    .en       (consume),
    .instr    (id_instr),
    .pc_plus4 (id_pc_plus4),
    .jump     (ctl_jump),
    .branch   (ctl_branch),
    .zero     (alu_zero),
    .taken    (taken),
    .target   (target)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_BOOT;
    else        state <= state_nxt;
  end

  // Next state and datapath strobes; a taken redirect overrides any fetch.
  always_comb begin
    state_nxt     = state;
    id_load_mem   = 1'b0;
    id_load_skid  = 1'b0;
    skid_wr       = 1'b0;
    pc_inc        = 1'b0;
    pc_to_target  = 1'b0;
    save_target   = 1'b0;
    pc_from_redir = 1'b0;
    case (state)
      S_BOOT: state_nxt = S_REQ;
      S_REQ: begin
        if (taken) begin
          // With ack the wrong-path word is simply dropped; without it the
          // request must finish at its current address first.
          if (imem_ack) pc_to_target = 1'b1;
          else begin
            save_target = 1'b1;
            state_nxt   = S_DROP;
          end
        end else if (imem_ack) begin
          if (id_stall) begin
            skid_wr   = 1'b1;
            state_nxt = S_HOLD;
          end else begin
            id_load_mem = 1'b1;
            pc_inc      = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (!id_stall) begin
          state_nxt = S_REQ;
          if (taken) pc_to_target = 1'b1;
          else begin
            id_load_skid = 1'b1;
            pc_inc       = 1'b1;
          end
        end
      end
      S_DROP: begin
        if (imem_ack) begin
          pc_from_redir = 1'b1;
          state_nxt     = S_REQ;
        end
      end
      default: state_nxt = S_BOOT;
    endcase
  end

  // PC, redirect target, skid and IF/ID registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      redir_pc    <= RESET_PC;
      skid        <= '0;
      id_valid    <= 1'b0;
      id_instr    <= '0;
      id_pc_plus4 <= '0;
    end else begin
      if (pc_to_target)       pc <= target;
      else if (pc_from_redir) pc <= redir_pc;
      else if (pc_inc)        pc <= pc_plus4;

      if (save_target) redir_pc <= target;

      if (skid_wr)    skid <= imem_rdata;
      else if (taken) skid <= '0;

      if (id_load_mem) begin
        id_valid    <= 1'b1;
        id_instr    <= imem_rdata;
        id_pc_plus4 <= pc_plus4;
      end else if (id_load_skid) begin
        id_valid    <= 1'b1;
        id_instr    <= skid;
        id_pc_plus4 <= pc_plus4;
      end else if (consume) begin
        id_valid <= 1'b0;
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  // Saturating counters: accepted words, taken redirects, hold/drop cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch <= '0;
      perf_flush <= '0;
      perf_stall <= '0;
    end else begin
      if ((id_load_mem | skid_wr) && perf_fetch != '1) perf_fetch <= perf_fetch + 32'd1;
      if (taken && perf_flush != '1)                   perf_flush <= perf_flush + 32'd1;
      if ((state == S_HOLD || state == S_DROP) && perf_stall != '1)
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: memory model, a small control-unit model,
// and a scoreboard of instructions expected to be consumed from IF/ID.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  localparam int ADDR_W = 32;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               id_valid;
  logic [INSTR_W-1:0] id_instr;
  logic [5:0]         id_opcode;
  logic [ADDR_W-1:0]  id_pc_plus4;
  logic               id_stall;
  logic               ctl_jump;
  logic               ctl_branch;
  logic               alu_zero;
  fetch_state_t       dbg_state;
`ifdef IF_PERF_CNT_EN
  logic [31:0]        perf_fetch, perf_flush, perf_stall;
`endif

  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  instr_fetch #(.ADDR_W(ADDR_W), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .id_opcode   (id_opcode),
    .id_pc_plus4 (id_pc_plus4),
    .id_stall    (id_stall),
    .ctl_jump    (ctl_jump),
    .ctl_branch  (ctl_branch),
    .alu_zero    (alu_zero),
`ifdef IF_PERF_CNT_EN
    .perf_fetch  (perf_fetch),
    .perf_flush  (perf_flush),
    .perf_stall  (perf_stall),
`endif
    .dbg_state   (dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  // Instruction memory image: a few control-flow words, unique filler elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_000C: return {OP_J, 26'h40};              // -> 0x100
      32'h0000_0104: return {OP_J, 26'h08};              // -> 0x20
      32'h0000_0020: return {OP_BEQ, 10'd0, 16'hFFFE};   // -> 0x1C
      32'h0000_0028: return {OP_BNE, 10'd0, 16'h0010};   // -> 0x6C
      32'h0000_006C: return {OP_BNE, 10'd0, 16'h0100};
      32'h0000_0080: return {OP_J, 26'h80};              // -> 0x200
      default:       return {6'b001000, 2'b00, a[23:0]};
    endcase
  endfunction

  assign imem_rdata = mem_word(imem_addr);
  assign ctl_jump   = (id_opcode == OP_J);
  assign ctl_branch = (id_opcode == OP_BEQ) || (id_opcode == OP_BNE);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] a);
    exp_q.push_back({a + 32'd4, mem_word(a)});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_if(input string tag, input logic v, input logic [31:0] pp4, input logic [31:0] addr);
    check({tag, "_valid"}, 64'(id_valid), 64'(v));
    if (v) check({tag, "_pc_plus4"}, 64'(id_pc_plus4), 64'(pp4));
    check({tag, "_addr"}, 64'(imem_addr), 64'(addr));
  endtask

  task automatic wait_addr(input logic [31:0] a, input int budget);
    int n = 0;
    while (!(imem_req === 1'b1 && imem_addr === a) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) begin
      checks++;
      failures++;
      $error("FAIL wait_addr observed=%h expected=%h", imem_addr, a);
    end
  endtask

  // Scoreboard: a word is consumed when valid and not stalled at the edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && id_valid === 1'b1 && id_stall === 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL sb_unexpected observed=%h expected=none", {id_pc_plus4, id_instr});
      end else begin
        check("sb_word", {id_pc_plus4, id_instr}, exp_q.pop_front());
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    imem_ack = 1'b1;
    id_stall = 1'b0;
    alu_zero = 1'b1;
    repeat (3) step();
    check("rst_req", 64'(imem_req), 64'd0);
    check("rst_addr", 64'(imem_addr), 64'h0);
    check("rst_valid", 64'(id_valid), 64'd0);
    check("rst_instr", 64'(id_instr), 64'h0);
    check("rst_pc_plus4", 64'(id_pc_plus4), 64'h0);
    check("rst_state", 64'(dbg_state), 64'(S_BOOT));

    foreach (exp_q[i]) exp_q.delete(i);
    push_word(32'h00); push_word(32'h04); push_word(32'h08); push_word(32'h0C);
    push_word(32'h100); push_word(32'h104);
    push_word(32'h20); push_word(32'h1C); push_word(32'h20); push_word(32'h24);
    push_word(32'h28); push_word(32'h6C); push_word(32'h70); push_word(32'h74);
    push_word(32'h78); push_word(32'h7C); push_word(32'h80); push_word(32'h200);

    // Cycle 1 after release is the boot cycle.
    rst_n = 1'b1;
    check("boot_req", 64'(imem_req), 64'd0);
    step(); check("c2_req", 64'(imem_req), 64'd1); chk_if("c2", 1'b0, 32'h0, 32'h0);
    step(); chk_if("c3", 1'b1, 32'h4, 32'h4);
    check("c3_instr", 64'(id_instr), 64'(mem_word(32'h0)));
    step(); chk_if("c4", 1'b1, 32'h8, 32'h8);
    step(); chk_if("c5", 1'b1, 32'hC, 32'hC);
    step(); chk_if("j_in_id", 1'b1, 32'h10, 32'h10);
    step(); chk_if("j_flush", 1'b0, 32'h0, 32'h100);
    step(); chk_if("j_target", 1'b1, 32'h104, 32'h104);
    step(); chk_if("j2_in_id", 1'b1, 32'h108, 32'h108);
    step(); chk_if("j2_flush", 1'b0, 32'h0, 32'h20);
    step(); chk_if("beq1_in_id", 1'b1, 32'h24, 32'h24);
    step(); chk_if("beq_taken", 1'b0, 32'h0, 32'h1C);
    alu_zero = 1'b0;
    step(); chk_if("beq_tgt_word", 1'b1, 32'h20, 32'h20);
    step(); chk_if("beq2_in_id", 1'b1, 32'h24, 32'h24);
    step(); chk_if("beq_not_taken", 1'b1, 32'h28, 32'h28);
    step(); chk_if("bne1_in_id", 1'b1, 32'h2C, 32'h2C);
    step(); chk_if("bne_taken", 1'b0, 32'h0, 32'h6C);
    alu_zero = 1'b1;
    step(); chk_if("bne2_in_id", 1'b1, 32'h70, 32'h70);
    step(); chk_if("bne_not_taken", 1'b1, 32'h74, 32'h74);

    // Stall for three cycles while the next word is acknowledged.
    id_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_req", 64'(imem_req), 64'd0);
      check("hold_state", 64'(dbg_state), 64'(S_HOLD));
      check("hold_pc_plus4", 64'(id_pc_plus4), 64'h74);
      check("hold_instr", 64'(id_instr), 64'(mem_word(32'h70)));
    end
    id_stall = 1'b0;
    step(); chk_if("skid_out", 1'b1, 32'h78, 32'h78);
    check("skid_instr", 64'(id_instr), 64'(mem_word(32'h74)));
    check("skid_req", 64'(imem_req), 64'd1);

    // Jump while the following request gets no ack for two cycles.
    wait_addr(32'h80, 10);
    step(); chk_if("j3_in_id", 1'b1, 32'h84, 32'h84);
    imem_ack = 1'b0;
    step(); chk_if("drop1", 1'b0, 32'h0, 32'h84);
    check("drop1_state", 64'(dbg_state), 64'(S_DROP));
    check("drop1_req", 64'(imem_req), 64'd1);
    step(); chk_if("drop2", 1'b0, 32'h0, 32'h84);
    imem_ack = 1'b1;
    step(); chk_if("drop_done", 1'b0, 32'h0, 32'h200);
    check("drop_done_state", 64'(dbg_state), 64'(S_REQ));
    step(); chk_if("drop_tgt_word", 1'b1, 32'h204, 32'h204);
    imem_ack = 1'b0;
    step(); chk_if("drain", 1'b0, 32'h0, 32'h204);
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    // Reset asserted while a request is outstanding.
    step();
    rst_n    = 1'b0;
    imem_ack = 1'b1;
    #1;
    check("mid_rst_req", 64'(imem_req), 64'd0);
    check("mid_rst_addr", 64'(imem_addr), 64'h0);
    check("mid_rst_valid", 64'(id_valid), 64'd0);
    check("mid_rst_instr", 64'(id_instr), 64'h0);
    step(); step();
    rst_n = 1'b1;
    check("reboot_req", 64'(imem_req), 64'd0);
    step(); chk_if("reboot_ack_ignored", 1'b0, 32'h0, 32'h0);
    imem_ack = 1'b0;
    step(); chk_if("reboot_req_held", 1'b0, 32'h0, 32'h0);
    check("reboot_req_high", 64'(imem_req), 64'd1);
    push_word(32'h0);
    imem_ack = 1'b1;
    step(); chk_if("reboot_first", 1'b1, 32'h4, 32'h4);
    imem_ack = 1'b0;
    step(); check("reboot_consumed", 64'(id_valid), 64'd0);
    check("sb_final_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
